// File: rtl/dcache_mem_port_if.sv
// Sysbus request/response channel between the line engine (master) and memory (slave).
// Request side is valid/ack; response side is valid with a combinational ack from the master.
interface dcache_mem_port_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
) ();
  logic                      reqcyc;
  logic                      reqack;
  logic [BUS_DATA_WIDTH-1:0] req;
  logic [BUS_TAG_WIDTH-1:0]  reqtag;
  logic                      respcyc;
  logic                      respack;
  logic [BUS_DATA_WIDTH-1:0] resp;
  logic [BUS_TAG_WIDTH-1:0]  resptag;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/dcache_mem_port.sv
// Moves one 8-beat cache line per request between the L1 dcache and the Sysbus (refill or writeback).
// Latency: writeback 10 cycles on a zero-wait bus; beats stall on reqack/respcyc; later requests ignored until IDLE.
module dcache_mem_port #(
  parameter int                       BUS_DATA_WIDTH = 64,
  parameter int                       BUS_TAG_WIDTH  = 13,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG       = 13'h1100,
  parameter logic [BUS_TAG_WIDTH-1:0] WRITE_TAG      = 13'h1101
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_req_read,
  input  logic                        in_req_writeback,
  input  logic [63:0]                 in_address,
  input  logic [8*BUS_DATA_WIDTH-1:0] in_wb_data,
  output logic [8*BUS_DATA_WIDTH-1:0] out_data,
  output logic [9:0]                  out_offset,
  output logic [9:0]                  out_offset_write,
  output logic                        out_busy,
  dcache_mem_port_if.master           bus
);

  localparam int         LINE_W = 8 * BUS_DATA_WIDTH;
  localparam logic [9:0] STEP   = 10'(BUS_DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE, WB_ADDR, WB_DATA, WB_DONE, RD_ADDR, RD_DATA, RD_DONE
  } state_t;

  state_t                    state_q, state_n;
  logic [2:0]                cnt_q, cnt_n, cnt_inc;
  logic [LINE_W-1:0]         line_q, line_n;
  logic [LINE_W-1:0]         data_q, data_n;
  logic [9:0]                off_q, off_n;
  logic [9:0]                offw_q, offw_n;
  logic                      busy_q;
  logic                      reqcyc_q, reqcyc_n;
  logic [BUS_DATA_WIDTH-1:0] req_q, req_n;
  logic [BUS_TAG_WIDTH-1:0]  reqtag_q, reqtag_n;
  logic                      take;

  assign cnt_inc = cnt_q + 3'd1;
  assign take    = (state_q == RD_DATA) && bus.respcyc && (bus.resptag == READ_TAG);

  assign bus.respack      = take;
  assign bus.reqcyc       = reqcyc_q;
  assign bus.req          = req_q;
  assign bus.reqtag       = reqtag_q;
  assign out_data         = data_q;
  assign out_offset       = off_q;
  assign out_offset_write = offw_q;
  assign out_busy         = busy_q;

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    line_n   = line_q;
    data_n   = data_q;
    off_n    = off_q;
    offw_n   = offw_q;
    reqcyc_n = reqcyc_q;
    req_n    = req_q;
    reqtag_n = reqtag_q;

    case (state_q)
      IDLE: begin
        off_n    = '0;
        offw_n   = '0;
        cnt_n    = '0;
        reqcyc_n = 1'b0;
        req_n    = '0;
        reqtag_n = '0;
        // Writeback wins so a dirty victim leaves before its refill overwrites the set.
        if (in_req_writeback) begin
          state_n  = WB_ADDR;
          line_n   = in_wb_data;
          reqcyc_n = 1'b1;
          req_n    = BUS_DATA_WIDTH'({in_address[63:6], 6'b0});
          reqtag_n = WRITE_TAG;
        end else if (in_req_read) begin
          state_n  = RD_ADDR;
          reqcyc_n = 1'b1;
          req_n    = BUS_DATA_WIDTH'({in_address[63:6], 6'b0});
          reqtag_n = READ_TAG;
        end
      end
      WB_ADDR: begin
        if (bus.reqack) begin
          state_n = WB_DATA;
          cnt_n   = '0;
          req_n   = line_q[BUS_DATA_WIDTH-1:0];
        end
      end
      WB_DATA: begin
        if (bus.reqack) begin
          offw_n = offw_q + STEP;
          if (cnt_q == 3'd7) begin
            state_n  = WB_DONE;
            cnt_n    = '0;
            reqcyc_n = 1'b0;
            req_n    = '0;
            reqtag_n = '0;
          end else begin
            cnt_n = cnt_inc;
            req_n = line_q[int'(cnt_inc) * BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
          end
        end
      end
      WB_DONE: begin
        state_n = IDLE;
        offw_n  = '0;
      end
      RD_ADDR: begin
        if (bus.reqack) begin
          state_n  = RD_DATA;
          reqcyc_n = 1'b0;
          req_n    = '0;
          reqtag_n = '0;
        end
      end
      RD_DATA: begin
        if (take) begin
          data_n[int'(cnt_q) * BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus.resp;
          off_n = off_q + STEP;
          cnt_n = cnt_inc;
          if (cnt_q == 3'd7) state_n = RD_DONE;
        end
      end
      RD_DONE: begin
        state_n = IDLE;
        off_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      line_q   <= '0;
      data_q   <= '0;
      off_q    <= '0;
      offw_q   <= '0;
      busy_q   <= 1'b0;
      reqcyc_q <= 1'b0;
      req_q    <= '0;
      reqtag_q <= '0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      line_q   <= line_n;
      data_q   <= data_n;
      off_q    <= off_n;
      offw_q   <= offw_n;
      busy_q   <= (state_n != IDLE);
      reqcyc_q <= reqcyc_n;
      req_q    <= req_n;
      reqtag_q <= reqtag_n;
    end
  end

endmodule

// File: tb/tb_dcache_mem_port.sv
// Directed bench for dcache_mem_port: refills, writebacks, priority, tag filtering, reset and response gaps.
module tb_dcache_mem_port;
  localparam logic [12:0] READ_TAG  = 13'h1100;
  localparam logic [12:0] WRITE_TAG = 13'h1101;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_req_read, in_req_writeback;
  logic [63:0]  in_address;
  logic [511:0] in_wb_data;
  logic [511:0] out_data;
  logic [9:0]   out_offset, out_offset_write;
  logic         out_busy;
  logic [511:0] model_line;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  dcache_mem_port_if bus ();

  dcache_mem_port dut (
    .clk              (clk),
    .reset            (reset),
    .in_req_read      (in_req_read),
    .in_req_writeback (in_req_writeback),
    .in_address       (in_address),
    .in_wb_data       (in_wb_data),
    .out_data         (out_data),
    .out_offset       (out_offset),
    .out_offset_write (out_offset_write),
    .out_busy         (out_busy),
    .bus              (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a refill request through the address phase; leaves the DUT in RD_DATA.
  task automatic start_refill(input logic [63:0] a);
    in_address  = a;
    in_req_read = 1'b1;
    bus.reqack  = 1'b1;
    tick();
    tick();
    bus.reqack  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_req_read = 0; in_req_writeback = 0; in_address = '0; in_wb_data = '0;
    bus.reqack = 0; bus.respcyc = 0; bus.resp = '0; bus.resptag = '0;
    model_line = '0;
    tick();
    tick();
    checks++;
    if ({out_busy, out_offset, out_offset_write, bus.reqcyc, bus.req, bus.reqtag, bus.respack} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b off=%0d offw=%0d reqcyc=%b req=%h tag=%h respack=%b, required all 0",
               out_busy, out_offset, out_offset_write, bus.reqcyc, bus.req, bus.reqtag, bus.respack);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0", out_data);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_refill_zero_wait();
    logic [63:0] v;
    in_address  = 64'h8000_1234;
    in_req_read = 1'b1;
    bus.reqack  = 1'b1;
    tick();
    checks++;
    if (bus.reqcyc !== 1'b1 || bus.req !== 64'h8000_1200 || bus.reqtag !== READ_TAG) begin
      errors++;
      $display("FAIL refill_addr: reqcyc=%b req=%h tag=%h, required 1/8000_1200/%h", bus.reqcyc, bus.req, bus.reqtag, READ_TAG);
    end
    checks++;
    if (out_busy !== 1'b1) begin
      errors++;
      $display("FAIL refill_busy: got %b, required 1", out_busy);
    end
    tick();
    bus.reqack = 1'b0;
    checks++;
    if (bus.reqcyc !== 1'b0) begin
      errors++;
      $display("FAIL refill_reqcyc_drop: got %b, required 0", bus.reqcyc);
    end
    for (int i = 0; i < 8; i++) begin
      v = 64'(i + 1) * 64'h11;
      bus.respcyc = 1'b1; bus.resp = v; bus.resptag = READ_TAG;
      model_line[64*i +: 64] = v;
      #1;
      checks++;
      if (bus.respack !== 1'b1) begin
        errors++;
        $display("FAIL refill_respack beat %0d: got %b, required 1", i, bus.respack);
      end
      tick();
      checks++;
      if (out_offset !== 10'(64 * (i + 1))) begin
        errors++;
        $display("FAIL refill_offset beat %0d: got %0d, required %0d", i, out_offset, 64 * (i + 1));
      end
    end
    bus.respcyc = 1'b0;
    checks++;
    if (out_data[63:0] !== 64'h11 || out_data[511:448] !== 64'h88) begin
      errors++;
      $display("FAIL refill_ends: low=%h high=%h, required 11/88", out_data[63:0], out_data[511:448]);
    end
    checks++;
    if (out_data !== model_line) begin
      errors++;
      $display("FAIL refill_line: got %h, required %h", out_data, model_line);
    end
    in_req_read = 1'b0;
    tick();
    checks++;
    if (out_offset !== 10'd0 || out_busy !== 1'b0 || out_data !== model_line) begin
      errors++;
      $display("FAIL refill_after_done: off=%0d busy=%b data_ok=%b, required 0/0/1", out_offset, out_busy, out_data === model_line);
    end
  endtask

  task automatic test_writeback_wait();
    logic [63:0] wexp [9];
    logic [9:0]  exp_ow;
    int acks, post, n512;
    in_address = 64'h0000_00ab_cdef_0a7f;
    for (int i = 0; i < 8; i++) in_wb_data[64*i +: 64] = 64'(i + 1);
    wexp[0] = 64'h0000_00ab_cdef_0a40;
    for (int k = 1; k < 9; k++) wexp[k] = 64'(k);
    in_req_writeback = 1'b1;
    bus.reqack = 1'b0;
    tick();
    in_wb_data = '1;
    in_address = '0;
    acks = 0; post = -1; n512 = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (acks < 9) exp_ow = (acks == 0) ? 10'd0 : 10'(64 * (acks - 1));
      else          exp_ow = (post == 0) ? 10'd512 : 10'd0;
      if (out_offset_write == 10'd512) n512++;
      checks++;
      if (out_offset_write !== exp_ow) begin
        errors++;
        $display("FAIL wb_offset cyc %0d: got %0d, required %0d", cyc, out_offset_write, exp_ow);
      end
      checks++;
      if (bus.reqcyc !== (acks < 9) || out_busy !== (acks < 9 || post == 0)) begin
        errors++;
        $display("FAIL wb_ctrl cyc %0d: reqcyc=%b busy=%b, required %b/%b", cyc, bus.reqcyc, out_busy, acks < 9, acks < 9 || post == 0);
      end
      if (acks < 9) begin
        checks++;
        if (bus.req !== wexp[acks] || bus.reqtag !== WRITE_TAG) begin
          errors++;
          $display("FAIL wb_beat %0d cyc %0d: req=%h tag=%h, required %h/%h", acks, cyc, bus.req, bus.reqtag, wexp[acks], WRITE_TAG);
        end
      end
      if (acks == 9 && post == 0) in_req_writeback = 1'b0;
      bus.reqack = (acks < 9) && (cyc % 2 == 1);
      if (bus.reqack) acks++;
      if (acks == 9) post++;
      tick();
    end
    bus.reqack = 1'b0;
    checks++;
    if (n512 != 1) begin
      errors++;
      $display("FAIL wb_512_count: saw %0d cycles at 512, required 1", n512);
    end
  endtask

  task automatic test_both_requests();
    for (int i = 0; i < 8; i++) in_wb_data[64*i +: 64] = 64'h7700 + 64'(i);
    in_address = 64'h1000;
    in_req_writeback = 1'b1;
    in_req_read = 1'b1;
    bus.reqack = 1'b1;
    tick();
    checks++;
    if (bus.reqcyc !== 1'b1 || bus.reqtag !== WRITE_TAG) begin
      errors++;
      $display("FAIL both_first: reqcyc=%b tag=%h, required 1/%h", bus.reqcyc, bus.reqtag, WRITE_TAG);
    end
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (out_offset_write !== 10'd512 || out_offset !== 10'd0) begin
      errors++;
      $display("FAIL both_wb_done: offw=%0d off=%0d, required 512/0", out_offset_write, out_offset);
    end
    in_req_writeback = 1'b0;
    tick();
    checks++;
    if (out_busy !== 1'b0 || out_offset_write !== 10'd0) begin
      errors++;
      $display("FAIL both_idle: busy=%b offw=%0d, required 0/0", out_busy, out_offset_write);
    end
    tick();
    checks++;
    if (bus.reqcyc !== 1'b1 || bus.reqtag !== READ_TAG || bus.req !== 64'h1000) begin
      errors++;
      $display("FAIL both_refill_start: reqcyc=%b tag=%h req=%h, required 1/%h/1000", bus.reqcyc, bus.reqtag, bus.req, READ_TAG);
    end
    tick();
    bus.reqack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.respcyc = 1'b1; bus.resp = 64'ha0 + 64'(i); bus.resptag = READ_TAG;
      model_line[64*i +: 64] = 64'ha0 + 64'(i);
      tick();
    end
    bus.respcyc = 1'b0;
    checks++;
    if (out_offset !== 10'd512 || out_data !== model_line) begin
      errors++;
      $display("FAIL both_refill_done: off=%0d data=%h, required 512/%h", out_offset, out_data, model_line);
    end
    in_req_read = 1'b0;
    tick();
  endtask

  task automatic test_foreign_tag();
    start_refill(64'h40);
    for (int i = 0; i < 2; i++) begin
      bus.respcyc = 1'b1; bus.resp = 64'hf00 + 64'(i); bus.resptag = READ_TAG;
      model_line[64*i +: 64] = 64'hf00 + 64'(i);
      tick();
    end
    bus.respcyc = 1'b1; bus.resp = 64'hdead; bus.resptag = 13'h0042;
    #1;
    checks++;
    if (bus.respack !== 1'b0) begin
      errors++;
      $display("FAIL foreign_respack: got %b, required 0", bus.respack);
    end
    tick();
    checks++;
    if (out_offset !== 10'd128 || out_data !== model_line) begin
      errors++;
      $display("FAIL foreign_ignored: off=%0d data=%h, required 128/%h", out_offset, out_data, model_line);
    end
    for (int i = 2; i < 8; i++) begin
      bus.respcyc = 1'b1; bus.resp = 64'hf00 + 64'(i); bus.resptag = READ_TAG;
      model_line[64*i +: 64] = 64'hf00 + 64'(i);
      #1;
      if (i == 2) begin
        checks++;
        if (bus.respack !== 1'b1) begin
          errors++;
          $display("FAIL foreign_next_ack: got %b, required 1", bus.respack);
        end
      end
      tick();
      if (i == 2) begin
        checks++;
        if (out_offset !== 10'd192 || out_data[191:128] !== 64'hf02) begin
          errors++;
          $display("FAIL foreign_next_beat: off=%0d beat2=%h, required 192/f02", out_offset, out_data[191:128]);
        end
      end
    end
    bus.respcyc = 1'b0;
    checks++;
    if (out_offset !== 10'd512 || out_data !== model_line) begin
      errors++;
      $display("FAIL foreign_line: off=%0d data=%h, required 512/%h", out_offset, out_data, model_line);
    end
    in_req_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_refill();
    start_refill(64'h2000);
    for (int i = 0; i < 3; i++) begin
      bus.respcyc = 1'b1; bus.resp = 64'hbad0 + 64'(i); bus.resptag = READ_TAG;
      tick();
    end
    bus.respcyc = 1'b0;
    reset = 1'b0;
    tick();
    model_line = '0;
    checks++;
    if ({out_busy, out_offset, out_offset_write, bus.reqcyc, bus.req, bus.reqtag, bus.respack} !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL midreset_clear: busy=%b off=%0d offw=%0d reqcyc=%b data=%h, required all 0",
               out_busy, out_offset, out_offset_write, bus.reqcyc, out_data);
    end
    reset = 1'b1;
    bus.reqack = 1'b1;
    tick();
    checks++;
    if (bus.reqcyc !== 1'b1 || bus.req !== 64'h2000) begin
      errors++;
      $display("FAIL midreset_restart: reqcyc=%b req=%h, required 1/2000", bus.reqcyc, bus.req);
    end
    tick();
    bus.reqack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.respcyc = 1'b1; bus.resp = 64'h5000 + 64'(i); bus.resptag = READ_TAG;
      model_line[64*i +: 64] = 64'h5000 + 64'(i);
      tick();
      if (i == 0) begin
        checks++;
        if (out_offset !== 10'd64 || out_data !== model_line) begin
          errors++;
          $display("FAIL midreset_beat0: off=%0d data=%h, required 64/%h", out_offset, out_data, model_line);
        end
      end
    end
    bus.respcyc = 1'b0;
    checks++;
    if (out_offset !== 10'd512 || out_data !== model_line) begin
      errors++;
      $display("FAIL midreset_line: off=%0d data=%h, required 512/%h", out_offset, out_data, model_line);
    end
    in_req_read = 1'b0;
    tick();
  endtask

  task automatic test_resp_gaps();
    int gaps [8] = '{0, 1, 2, 3, 1, 0, 3, 2};
    start_refill(64'h3_0000_0040);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        bus.respcyc = 1'b0;
        tick();
        checks++;
        if (out_offset !== 10'(64 * i)) begin
          errors++;
          $display("FAIL gaps_hold beat %0d gap %0d: off=%0d, required %0d", i, g, out_offset, 64 * i);
        end
      end
      bus.respcyc = 1'b1; bus.resp = 64'hc0de_0000 + 64'(i); bus.resptag = READ_TAG;
      model_line[64*i +: 64] = 64'hc0de_0000 + 64'(i);
      tick();
      checks++;
      if (out_offset !== 10'(64 * (i + 1))) begin
        errors++;
        $display("FAIL gaps_step beat %0d: off=%0d, required %0d", i, out_offset, 64 * (i + 1));
      end
    end
    bus.respcyc = 1'b0;
    checks++;
    if (out_data !== model_line) begin
      errors++;
      $display("FAIL gaps_line: got %h, required %h", out_data, model_line);
    end
    in_req_read = 1'b0;
    tick();
    checks++;
    if (out_busy !== 1'b0 || out_offset !== 10'd0) begin
      errors++;
      $display("FAIL gaps_idle: busy=%b off=%0d, required 0/0", out_busy, out_offset);
    end
  endtask

  initial begin
    test_reset();
    test_refill_zero_wait();
    test_writeback_wait();
    test_both_requests();
    test_foreign_tag();
    test_reset_mid_refill();
    test_resp_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dcache_mem_port.md
Name: dcache_mem_port

Overview:
- Memory-side line transfer engine directly below the L1 data cache.
- Accepts one line-refill or one dirty-line writeback request at a time from the dcache, and moves the 512-bit line over the 64-bit Sysbus as 8 beats.
- For refills, assembles the beats and presents the full line with a bit-count progress offset, which the dcache polls for completion (offset == 512).
- For writebacks, serialises the cache line onto the bus and reports a write progress offset the same way.

Parameters:
- BUS_DATA_WIDTH, 64, bus beat width in bits; the line is 8 beats.
- BUS_TAG_WIDTH, 13, width of the Sysbus request and response tags.
- READ_TAG, 13'h1100, tag driven on read requests; response beats must match it.
- WRITE_TAG, 13'h1101, tag driven on write requests.

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-low (0 = reset)
- in_req_read  in  1  dcache requests a line refill
- in_req_writeback  in  1  dcache requests a dirty-line writeback
- in_address  in  64  line address; bits [5:0] are ignored and forced to 0 on the bus
- in_wb_data  in  512  line to write back; beat i = bits [64i+63:64i]
- out_data  out  512  assembled refill line
- out_offset  out  10  refill progress in bits: 0..512, step 64
- out_offset_write  out  10  writeback progress in bits: 0..512, step 64
- out_busy  out  1  high whenever the FSM is not in IDLE
- bus_reqcyc  out  1  request valid
- bus_reqack  in  1  request beat accepted
- bus_req  out  64  address beat or data beat
- bus_reqtag  out  BUS_TAG_WIDTH  request tag
- bus_respcyc  in  1  response beat valid
- bus_respack  out  1  response beat acknowledged
- bus_resp  in  64  response data
- bus_resptag  in  BUS_TAG_WIDTH  response tag

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE.
  - All outputs 0, including out_data, both offsets, bus_reqcyc and bus_respack.
  - Reset mid-transfer aborts immediately; partial line and beat counter are cleared.
- States: IDLE, WB_ADDR, WB_DATA, WB_DONE, RD_ADDR, RD_DATA, RD_DONE.
- IDLE:
  - Both offsets are 0.
  - in_req_writeback=1 -> WB_ADDR. This has priority when both requests are high.
  - Else in_req_read=1 -> RD_ADDR.
  - The address and in_wb_data are latched on the transition. Later changes to the inputs are ignored until the next IDLE.
- WB_ADDR:
  - Drives reqcyc=1, req={addr[63:6],6'b0}, reqtag=WRITE_TAG.
  - On reqack -> WB_DATA with beat counter=0.
- WB_DATA:
  - Drives reqcyc=1, req=latched line beat[counter], reqtag=WRITE_TAG.
  - Each reqack advances the counter and adds 64 to out_offset_write.
  - The beat is held unchanged until acked.
  - After the 8th ack: out_offset_write=512, state -> WB_DONE.
- WB_DONE:
  - Holds out_offset_write=512 for exactly one cycle, with reqcyc=0.
  - Then -> IDLE; out_offset_write returns to 0.
- RD_ADDR:
  - Drives reqcyc=1, req={addr[63:6],6'b0}, reqtag=READ_TAG.
  - On reqack -> RD_DATA. reqcyc drops the cycle after the ack.
- RD_DATA:
  - A beat is taken when respcyc=1 and resptag==READ_TAG.
  - bus_respack=1 in the same cycle, combinationally from respcyc and the tag match.
  - The beat is written to out_data[64*counter +: 64]; the counter increments and out_offset increments by 64.
  - Beats with a non-matching tag are not acked and not stored.
  - Gaps between beats (respcyc=0) are allowed, with no timeout.
  - After the 8th beat: out_offset=512, state -> RD_DONE.
- RD_DONE:
  - Holds out_offset=512 and a stable out_data for exactly one cycle, so the dcache captures the line on that posedge.
  - Then -> IDLE; out_offset returns to 0.
  - out_data keeps its value until the next refill's first beat.
- Requests arriving in a non-IDLE state are ignored (no queueing).
- The dcache must keep its request asserted until it observes offset==512.
- A request still high in the IDLE cycle after a DONE state starts a new transfer. The dcache is responsible for dropping it.
- Latency, with zero-wait bus:
  - Writeback: addr ack + 8 data acks + 1 DONE cycle = 10 cycles from the request.
  - Refill: addr ack + N response cycles + 1 DONE cycle.
- Beat counter is 3 bits; offsets are 10 bits and never exceed 512.
- Outputs are registered except bus_respack.

Test Plan:
- Refill, zero-wait bus:
  - Stimulus: in_req_read=1, in_address=0x8000_1234; response beats 0x11..0x88 back-to-back.
  - Required: bus_req=0x8000_1200 with tag READ_TAG; out_offset steps 64,128..512.
  - Required: out_data[63:0]=0x11 and out_data[511:448]=0x88, valid in RD_DONE for one cycle; offset 0 in the following cycle.
- Writeback with wait states:
  - Stimulus: in_req_writeback=1, in_wb_data beat i = i+1; reqack low on alternate cycles.
  - Required: 9 accepted beats (address, then 1..8); each data beat held while unacked; out_offset_write reaches 512 once, one cycle.
- Both requests high in IDLE:
  - Required: writeback runs first; after WB_DONE and return to IDLE, the refill starts.
- Foreign response tag:
  - Stimulus: a respcyc beat with resptag != READ_TAG inside RD_DATA.
  - Required: respack=0, out_data and out_offset unchanged; the next matching beat is accepted.
- Reset mid-refill:
  - Stimulus: reset=0 after 3 beats.
  - Required: next cycle all outputs 0 and state IDLE; a new refill assembles cleanly from beat 0.
- Response gaps:
  - Stimulus: 8 beats separated by 0..3 idle cycles.
  - Required: correct line assembled; offset increments only on accepted beats.
